// File: rtl/scaler_pkg.sv
// Shared types and constants for the ping-pong scaler line-buffer controller.
package scaler_pkg;

  localparam int unsigned DefAddrW = 12;
  localparam int unsigned DefFracW = 8;
  localparam int unsigned NumSlots = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRead
  } rd_state_e;

endpackage

// File: rtl/scaler_hdda.sv
// Horizontal DDA for nearest-neighbour scaling: saturating source accumulator,
// source index clamp and output issue counter.
module scaler_hdda
  import scaler_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned FRAC_W = DefFracW,
  parameter int unsigned WID_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clear,
  input  logic [ADDR_W+FRAC_W-2:0] step,
  input  logic [WID_W-1:0]         in_width,
  input  logic [WID_W-1:0]         out_width,
  output logic [ADDR_W-2:0]        src_x,
  output logic                     issue,
  output logic                     last
);

  localparam int unsigned AccW = ADDR_W + FRAC_W;

  logic [AccW-1:0]   acc_q, acc_d;
  logic [AccW:0]     sum;
  logic [ADDR_W-1:0] int_x, max_x;
  logic [WID_W-1:0]  cnt_q;
  logic              active_q;

  always_comb begin
    sum   = {1'b0, acc_q} + {2'b00, step};
    acc_d = sum[AccW] ? '1 : sum[AccW-1:0];
    int_x = acc_q[AccW-1:FRAC_W];
    max_x = (in_width == '0) ? '0 : ADDR_W'(in_width - 1'b1);
    src_x = (int_x > max_x) ? max_x[ADDR_W-2:0] : int_x[ADDR_W-2:0];
  end

  assign issue = active_q;
  assign last  = active_q && (cnt_q == out_width - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (clear) begin
      active_q <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      // A zero-width line never becomes active, so nothing is issued.
      active_q <= (out_width != '0);
    end else if (active_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (last) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/scaler_line_ctrl.sv
// Ping-pong line-buffer controller: writes input lines into two RAM slots and
// reads a full slot back as one horizontally scaled output line.
module scaler_line_ctrl
  import scaler_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned FRAC_W = DefFracW,
  parameter int unsigned WID_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WID_W-1:0]         cfg_in_width,
  input  logic [WID_W-1:0]         cfg_out_width,
  input  logic [ADDR_W+FRAC_W-2:0] cfg_h_step,
  input  logic                     in_vs,
  input  logic                     in_de,
  input  logic [7:0]               in_data,
  output logic                     ram_wr_en,
  output logic [ADDR_W-1:0]        ram_wr_addr,
  output logic [7:0]               ram_wr_data,
  output logic [ADDR_W-1:0]        ram_rd_addr,
  input  logic [7:0]               ram_rd_data,
  input  logic                     out_req,
  output logic                     out_busy,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_last,
  output logic                     status_ovf
);

  localparam int unsigned XW = ADDR_W - 1;
  localparam logic [WID_W-1:0] SlotPixels = WID_W'(2 ** XW);

  logic [WID_W-1:0]    in_w_eff, wr_x_q;
  logic [NumSlots-1:0] full_q, set_mask, clr_mask;
  logic                wr_slot_q, rd_slot_q, in_de_q, drop_q;
  logic                de_rise, de_fall, drop_now, wr_fire;
  rd_state_e           state_q, state_d;
  logic                start, release_slot;
  logic [XW-1:0]       src_x;
  logic                issue, last;
  logic                out_valid_q, out_last_q, ovf_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [7:0]          wr_data_q;

  scaler_hdda #(
    .ADDR_W (ADDR_W),
    .FRAC_W (FRAC_W),
    .WID_W  (WID_W)
  ) u_hdda (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (in_vs),
    .step      (cfg_h_step),
    .in_width  (in_w_eff),
    .out_width (cfg_out_width),
    .src_x     (src_x),
    .issue     (issue),
    .last      (last)
  );

  always_comb begin
    in_w_eff = (cfg_in_width > SlotPixels) ? SlotPixels : cfg_in_width;
    de_rise  = in_de & ~in_de_q;
    de_fall  = ~in_de & in_de_q;
    // Drop decision is taken once at line start and held for the whole line.
    drop_now = de_rise ? full_q[wr_slot_q] : drop_q;
    wr_fire  = in_de & ~drop_now & (wr_x_q < in_w_eff);
    set_mask = '0;
    if (de_fall && (wr_x_q != '0)) set_mask[wr_slot_q] = 1'b1;

    start        = 1'b0;
    release_slot = 1'b0;
    state_d      = state_q;
    unique case (state_q)
      StIdle: begin
        if (out_req && !out_valid_q) begin
          if (full_q[rd_slot_q]) begin
            start   = 1'b1;
            state_d = StRead;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (full_q[rd_slot_q]) begin
          start   = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        if (!issue || last) begin
          release_slot = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    clr_mask = '0;
    if (release_slot) clr_mask[rd_slot_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= '0;
      wr_slot_q   <= 1'b0;
      rd_slot_q   <= 1'b0;
      wr_x_q      <= '0;
      in_de_q     <= 1'b0;
      drop_q      <= 1'b0;
      ovf_q       <= 1'b0;
      state_q     <= StIdle;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (in_vs) begin
      full_q      <= '0;
      wr_slot_q   <= 1'b0;
      rd_slot_q   <= 1'b0;
      wr_x_q      <= '0;
      in_de_q     <= in_de;
      drop_q      <= 1'b0;
      ovf_q       <= 1'b0;
      state_q     <= StIdle;
      wr_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      in_de_q <= in_de;
      full_q  <= (full_q | set_mask) & ~clr_mask;
      if (de_fall) begin
        wr_x_q <= '0;
        drop_q <= 1'b0;
        if (wr_x_q != '0) wr_slot_q <= ~wr_slot_q;
      end else if (wr_fire) begin
        wr_x_q <= wr_x_q + 1'b1;
      end
      if (de_rise) drop_q <= full_q[wr_slot_q];
      if (de_rise && full_q[wr_slot_q]) ovf_q <= 1'b1;
      wr_en_q <= wr_fire;
      if (wr_fire) begin
        wr_addr_q <= {wr_slot_q, wr_x_q[XW-1:0]};
        wr_data_q <= in_data;
      end
      state_q <= state_d;
      if (release_slot) rd_slot_q <= ~rd_slot_q;
      out_valid_q <= issue;
      out_last_q  <= last;
    end
  end

  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  // RAM has no output register, so the address is driven straight from the DDA.
  assign ram_rd_addr = {rd_slot_q, src_x};
  assign out_busy    = (state_q != StIdle) | out_valid_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_valid_q ? ram_rd_data : 8'h00;
  assign status_ovf  = ovf_q;

endmodule

// File: tb/tb_scaler_line_ctrl.sv
// Directed self-checking bench for scaler_line_ctrl with a behavioural 4096x8 RAM.
module tb_scaler_line_ctrl;

  logic        clk;
  logic        rst_n;
  logic [11:0] cfg_in_width, cfg_out_width;
  logic [18:0] cfg_h_step;
  logic        in_vs, in_de;
  logic [7:0]  in_data;
  logic        ram_wr_en;
  logic [11:0] ram_wr_addr, ram_rd_addr;
  logic [7:0]  ram_wr_data, ram_rd_data;
  logic        out_req, out_busy, out_valid, out_last, status_ovf;
  logic [7:0]  out_data;

  scaler_line_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_in_width  (cfg_in_width),
    .cfg_out_width (cfg_out_width),
    .cfg_h_step    (cfg_h_step),
    .in_vs         (in_vs),
    .in_de         (in_de),
    .in_data       (in_data),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_data   (ram_rd_data),
    .out_req       (out_req),
    .out_busy      (out_busy),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .status_ovf    (status_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [4096];
  int         wr_count = 0;
  always @(posedge clk) begin
    if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
      wr_count <= wr_count + 1;
    end
    ram_rd_data <= mem[ram_rd_addr];
  end

  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] ev [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_line(input int n, input logic [7:0] base, input int tail);
    for (int i = 0; i < n; i++) begin
      in_de   = 1'b1;
      in_data = base + 8'(i);
      @(negedge clk);
    end
    in_de   = 1'b0;
    in_data = 8'h00;
    repeat (tail) @(negedge clk);
  endtask

  task automatic read_line(input string tag, input bit do_req, input int n,
                           input logic [11:0] addr0);
    int got;
    got = 0;
    if (do_req) begin
      out_req = 1'b1;
      @(negedge clk);
      out_req = 1'b0;
      check({tag, " busy"}, out_busy, 1);
      check({tag, " addr0"}, ram_rd_addr, addr0);
    end
    for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
      if (out_valid) begin
        check({tag, " data"}, out_data, ev[got]);
        check({tag, " last"}, out_last, (got == n - 1));
        got++;
      end
      @(negedge clk);
    end
    check({tag, " count"}, got, n);
    check({tag, " busy end"}, out_busy, 0);
  endtask

  task automatic count_valid(input int cycles, output int vcnt);
    vcnt = 0;
    for (int c = 0; c < cycles; c++) begin
      if (out_valid) vcnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int wc;
    int vcnt;
    rst_n = 1'b0; in_vs = 1'b0; in_de = 1'b0; in_data = 8'h00; out_req = 1'b0;
    cfg_in_width = 12'd8; cfg_out_width = 12'd8; cfg_h_step = 19'h100;
    repeat (2) @(negedge clk);
    check("rst wr_en", ram_wr_en, 0);
    check("rst wr_addr", ram_wr_addr, 0);
    check("rst wr_data", ram_wr_data, 0);
    check("rst rd_addr", ram_rd_addr, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_busy", out_busy, 0);
    check("rst out_last", out_last, 0);
    check("rst out_data", out_data, 0);
    check("rst ovf", status_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic pass-through into slot 0.
    wc = wr_count;
    write_line(8, 8'h10, 3);
    check("basic writes", wr_count - wc, 8);
    ev = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    read_line("basic", 1'b1, 8, 12'h000);

    // Upscale x2 from slot 1.
    cfg_in_width = 12'd4; cfg_out_width = 12'd8; cfg_h_step = 19'h080;
    wc = wr_count;
    write_line(4, 8'h40, 3);
    check("up writes", wr_count - wc, 4);
    ev = '{8'h40, 8'h40, 8'h41, 8'h41, 8'h42, 8'h42, 8'h43, 8'h43};
    read_line("up", 1'b1, 8, 12'h800);

    // Downscale 1.5 then step 2 with clamp to the last source pixel.
    cfg_in_width = 12'd5; cfg_out_width = 12'd4; cfg_h_step = 19'h180;
    write_line(5, 8'h60, 3);
    ev = '{8'h60, 8'h61, 8'h63, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00};
    read_line("down", 1'b1, 4, 12'h000);
    cfg_h_step = 19'h200;
    write_line(5, 8'h70, 3);
    ev = '{8'h70, 8'h72, 8'h74, 8'h74, 8'h00, 8'h00, 8'h00, 8'h00};
    read_line("clamp", 1'b1, 4, 12'h800);

    // Overflow: third line finds slot 0 still full.
    cfg_in_width = 12'd4; cfg_out_width = 12'd4; cfg_h_step = 19'h100;
    wc = wr_count;
    write_line(4, 8'h80, 3);
    write_line(4, 8'h90, 3);
    write_line(4, 8'hA0, 3);
    check("ovf writes", wr_count - wc, 8);
    check("ovf flag", status_ovf, 1);
    ev = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h00, 8'h00, 8'h00, 8'h00};
    read_line("ovf rd0", 1'b1, 4, 12'h000);
    ev = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h00, 8'h00, 8'h00, 8'h00};
    read_line("ovf rd1", 1'b1, 4, 12'h800);

    // Zero-width output releases the slot without pixels.
    write_line(4, 8'hB0, 3);
    cfg_out_width = 12'd0;
    out_req = 1'b1;
    @(negedge clk);
    out_req = 1'b0;
    count_valid(6, vcnt);
    check("zero valid", vcnt, 0);
    check("zero busy", out_busy, 0);
    cfg_out_width = 12'd4;
    write_line(4, 8'hC0, 3);
    ev = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
    read_line("zero next", 1'b1, 4, 12'h800);

    // Request with both slots empty waits for the next line.
    out_req = 1'b1;
    @(negedge clk);
    out_req = 1'b0;
    count_valid(4, vcnt);
    check("wait busy", out_busy, 1);
    check("wait valid", vcnt, 0);
    write_line(4, 8'hD0, 1);
    ev = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'h00, 8'h00, 8'h00, 8'h00};
    read_line("wait", 1'b0, 4, 12'h000);

    // Frame start aborts a read in progress and empties both slots.
    cfg_out_width = 12'd8; cfg_h_step = 19'h080;
    write_line(4, 8'hE0, 3);
    write_line(4, 8'hE8, 3);
    check("abort ovf pre", status_ovf, 1);
    out_req = 1'b1;
    @(negedge clk);
    out_req = 1'b0;
    @(negedge clk);
    check("abort valid pre", out_valid, 1);
    check("abort data pre", out_data, 8'hE0);
    @(negedge clk);
    in_vs = 1'b1;
    @(negedge clk);
    in_vs = 1'b0;
    check("abort valid", out_valid, 0);
    check("abort busy", out_busy, 0);
    check("abort ovf", status_ovf, 0);
    out_req = 1'b1;
    @(negedge clk);
    out_req = 1'b0;
    count_valid(4, vcnt);
    check("abort empty busy", out_busy, 1);
    check("abort empty valid", vcnt, 0);
    in_vs = 1'b1;
    @(negedge clk);
    in_vs = 1'b0;
    check("abort wait busy", out_busy, 0);

    // Asynchronous reset in the middle of a write burst.
    cfg_in_width = 12'd8; cfg_out_width = 12'd4; cfg_h_step = 19'h100;
    for (int i = 0; i < 3; i++) begin
      in_de   = 1'b1;
      in_data = 8'hF0 + 8'(i);
      @(negedge clk);
    end
    #1;
    rst_n = 1'b0;
    in_de = 1'b0;
    #1;
    check("arst wr_en", ram_wr_en, 0);
    check("arst wr_addr", ram_wr_addr, 0);
    check("arst wr_data", ram_wr_data, 0);
    check("arst rd_addr", ram_rd_addr, 0);
    check("arst busy", out_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_de   = 1'b1;
    in_data = 8'h50;
    @(negedge clk);
    check("post rst wr_en", ram_wr_en, 1);
    check("post rst wr_addr", ram_wr_addr, 12'h000);
    check("post rst wr_data", ram_wr_data, 8'h50);
    for (int i = 1; i < 4; i++) begin
      in_data = 8'h50 + 8'(i);
      @(negedge clk);
    end
    in_de = 1'b0;
    repeat (3) @(negedge clk);
    ev = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h00, 8'h00, 8'h00, 8'h00};
    read_line("post rst", 1'b1, 4, 12'h000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/scaler_line_ctrl.md
# scaler_line_ctrl

Ping-pong line-buffer controller that sequences the 4096×8 `ram_scaler` simple dual-port RAM for the HDMI scaler path. It writes each incoming video line into one of two 2048-pixel slots. On request it reads a full slot back as one horizontally scaled output line, using a fixed-point DDA (nearest-neighbour). Sits between the input video timing front-end and the scaler output formatter, and owns both RAM ports.

## Interface
- `ADDR_W`, 12: RAM address width; MSB selects the slot, low `ADDR_W-1` bits are the pixel index.
- `FRAC_W`, 8: fractional bits of the horizontal step.
- `WID_W`, 12: width of the line-length configuration fields.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: single clock for both RAM ports.
- `rst_n`, in, 1: asynchronous active-low reset.
- `cfg_in_width`, in, `WID_W`: input pixels per line, 1..2048; larger values are clamped to 2048.
- `cfg_out_width`, in, `WID_W`: output pixels per line, 1..4095; 0 means an output line is released with no pixels.
- `cfg_h_step`, in, `ADDR_W-1+FRAC_W`: source advance per output pixel, unsigned Q11.8.
- `in_vs`, in, 1: frame-start pulse.
- `in_de`, in, 1: input pixel valid / active line.
- `in_data`, in, 8: input pixel.
- `ram_wr_en`, out, 1: RAM write enable.
- `ram_wr_addr`, out, `ADDR_W`: RAM write address.
- `ram_wr_data`, out, 8: RAM write data.
- `ram_rd_addr`, out, `ADDR_W`: RAM read address.
- `ram_rd_data`, in, 8: RAM read data, valid one cycle after `ram_rd_addr` (no output register).
- `out_req`, in, 1: pulse requesting one output line.
- `out_busy`, out, 1: request pending or line in progress.
- `out_valid`, out, 1: `out_data` valid.
- `out_data`, out, 8: output pixel (`ram_rd_data` passed through).
- `out_last`, out, 1: last pixel of the output line.
- `status_ovf`, out, 1: sticky; an input line was dropped.

## Operation
- **Write side**
  - `wr_slot` and `wr_x` start at 0.
  - Each cycle with `in_de`=1 and `wr_x` < `cfg_in_width` registers a write: `ram_wr_addr` = {`wr_slot`, `wr_x`}, `ram_wr_data` = `in_data`, then `wr_x`++.
  - Pixels beyond `cfg_in_width` are discarded.
- **Line end**
  - Detected on the `in_de` falling edge.
  - If `wr_x` > 0: set `full[wr_slot]`, toggle `wr_slot`. Always clear `wr_x`.
- **Drop**
  - If `full[wr_slot]`=1 on an `in_de` rising edge, the whole line is dropped.
  - No writes occur, `status_ovf` is set, and the slot is not toggled.
- **Read FSM**
  - IDLE: `out_req` sets the pending bit. Go to READ if `full[rd_slot]`, else WAIT.
  - WAIT: go to READ when `full[rd_slot]`.
  - READ: issue `cfg_out_width` addresses, one per cycle: `ram_rd_addr` = {`rd_slot`, min(acc>>`FRAC_W`, `cfg_in_width`-1)}, then acc += `cfg_h_step`. acc starts at 0 and is `ADDR_W+FRAC_W` bits wide, saturating.
  - On the last issue: clear `full[rd_slot]`, toggle `rd_slot`, return to IDLE.
  - READ with `cfg_out_width`=0: release the slot immediately and assert no `out_valid`.
- **Request handling**: `out_req` while busy is ignored.
- **Simultaneous events**: a write-side set and a read-side clear of different slots in the same cycle both take effect. The same slot cannot be set and cleared in the same cycle, by construction.
- **`in_vs`** (highest priority, below reset):
  - clears `full[1:0]`, `wr_slot`, `rd_slot`, `wr_x`, pending and `status_ovf`;
  - aborts READ/WAIT to IDLE, suppressing any further `out_valid`;
  - a write registered in that cycle is cancelled.

## Timing
- **Reset values**: all outputs 0 (`ram_*` addresses/data 0, `out_*` 0, `status_ovf` 0); FSM in IDLE.
- **Write latency**: `in_de`/`in_data` at cycle t appear as `ram_wr_en`/`ram_wr_data` at t+1.
- **Slot full**: `full` is set at t+1 after the falling edge observed at t.
- **Read latency**: `out_req` at t with the slot full puts the first `ram_rd_addr` at t+1.
  - `out_valid` runs from t+2 to t+1+`cfg_out_width`.
  - `out_last` is asserted with the final `out_valid`.
- **`out_busy`**: high from t+1 until the cycle after `out_last`.
- **Throughput**: one output pixel per cycle, no bubbles within a line.

## Structure
- **Package `scaler_pkg`**: read-FSM state enum (IDLE, WAIT, READ), `ADDR_W`/`FRAC_W` defaults, slot count constant (2).
- **Sub-module `scaler_hdda`**: accumulator, clamp and issue counter.
  - Inputs: start, step, in_width, out_width.
  - Outputs: src_x, issue, last.
- The top level holds the write counter, full flags, FSM and output pipeline register.

## Test plan
- **Basic pass**: `cfg_in_width`=8, `cfg_out_width`=8, step=0x100; write line 0..7; `out_req` → `out_data` 0..7, `out_last` on the 8th, `ram_rd_addr` 0x000..0x007.
- **Upscale**: `cfg_in_width`=4, `cfg_out_width`=8, step=0x080 → source indices 0,0,1,1,2,2,3,3.
- **Downscale and clamp**: `cfg_in_width`=5, `cfg_out_width`=4, step=0x180 → indices 0,1,3,4.
  - step=0x200 with `cfg_out_width`=4 → 0,2,4,4 (clamped).
- **Overflow**: three input lines with no `out_req` → third dropped, no `ram_wr_en` for it, `status_ovf`=1.
  - Then two reads return lines 1 and 2 from slots 0 and 1 (addresses 0x000+, 0x800+).
- **Wait and abort**: `out_req` with both slots empty → `out_busy`=1, no `out_valid`; a line completes → read starts.
  - `in_vs` mid-READ → `out_valid` stops next cycle, `full`=0, `status_ovf`=0.
- **Async reset mid-line**: `rst_n` low during a write burst → all outputs 0 immediately.
  - After release, a clean line is written to slot 0 from index 0.
